ram_burst_ctrl: RTL

Burst initiator for one port of the team's RAM blocks: it drives the `ram_if.ctrl` side of the `ram_if` interface that the `ram2p`/`ram5p` memories consume on their `ram_if.mem` ports. Client logic issues burst commands (start address, length, direction) through a valid/ready handshake. The block streams write data into the RAM, or streams read data out through a small credit-controlled output FIFO that absorbs the RAM's one-cycle read latency and downstream backpressure. It sits between DMA/packet logic and a shared dual-port RAM.

---
 rtl/ram_burst_ctrl_if.sv | 16 +
 rtl/ram_burst_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl_if.sv
// ram_if: single RAM port bundle shared by ram_burst_ctrl and the RAM blocks.
// ctrl side drives we/din/addr; mem side returns dout one cycle after addr.
interface ram_if #(
   parameter int AWID = 8,
   parameter int DWID = 16
) (
   input logic clk
);
   logic            we;
   logic [DWID-1:0] din;
   logic [AWID-1:0] addr;
   logic [DWID-1:0] dout;

   modport ctrl (output we, output din, output addr, input dout);
   modport mem  (input clk, input we, input din, input addr, output dout);
endinterface

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst initiator for one RAM port (write stream, credit-limited read stream).
// Optional RAM_BURST_CTRL_INIT_EN: zero-fill the whole RAM after reset before accepting commands.
module ram_burst_ctrl #(
   parameter int DEPTH = 256,
   parameter int AWID  = 8,
   parameter int DWID  = 16,
   parameter int LWID  = 8
) (
   input  logic            clk,
   input  logic            rst,
   ram_if.ctrl             ram,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_write,
   input  logic [AWID-1:0] cmd_addr,
   input  logic [LWID-1:0] cmd_len,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [DWID-1:0] wr_data,
   output logic            rd_valid,
   input  logic            rd_ready,
   output logic [DWID-1:0] rd_data,
   output logic            busy,
   output logic            done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN
`ifdef RAM_BURST_CTRL_INIT_EN
      , S_INIT
`endif
   } state_t;

`ifdef RAM_BURST_CTRL_INIT_EN
   localparam state_t RST_STATE = S_INIT;
   localparam logic   RST_CRDY  = 1'b0;
`else
   localparam state_t RST_STATE = S_IDLE;
   localparam logic   RST_CRDY  = 1'b1;
`endif

   state_t          state_q, state_d;
   logic [AWID-1:0] addr_q, addr_d;
   logic [LWID-1:0] cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [AWID-1:0] raddr_q, raddr_d;
   logic [DWID-1:0] din_q, din_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            wr_ready_q, wr_ready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [1:0]      infl_q, infl_d;
   logic [DWID-1:0] fifo_mem [4];
   logic [1:0]      wp_q, rp_q;
   logic [2:0]      fcnt_q, fcnt_d;
   logic [3:0]      occ;
   logic            issue, push, pop;

   function automatic logic [AWID-1:0] nxt(input logic [AWID-1:0] a);
      return (a == AWID'(DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

   // Read credit: words in the FIFO plus words still in the RAM pipe never exceed 4.
   assign occ    = 4'(fcnt_q) + 4'(infl_q[0]) + 4'(infl_q[1]);
   assign issue  = (state_q == S_READ) && (occ < 4'd4);
   assign push   = infl_q[1];
   assign pop    = (fcnt_q != 3'd0) && rd_ready;
   assign fcnt_d = fcnt_q + 3'(push) - 3'(pop);
   assign infl_d = {infl_q[0], issue};

   // Next-state and next registered-output values.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      raddr_d = raddr_q;
      din_d   = din_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               addr_d  = cmd_addr;
               cnt_d   = cmd_len;
               state_d = cmd_write ? S_WRITE : S_READ;
            end
         end
         S_WRITE: begin
            if (wr_valid && wr_ready_q) begin
               we_d    = 1'b1;
               raddr_d = addr_q;
               din_d   = wr_data;
               addr_d  = nxt(addr_q);
               cnt_d   = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         S_READ: begin
            if (issue) begin
               raddr_d = addr_q;
               addr_d  = nxt(addr_q);
               cnt_d   = cnt_q - 1'b1;
               if (cnt_q == '0)
                  state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (infl_q == 2'b00 && fcnt_d == 3'd0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
`ifdef RAM_BURST_CTRL_INIT_EN
         S_INIT: begin
            we_d    = 1'b1;
            raddr_d = addr_q;
            din_d   = '0;
            addr_d  = nxt(addr_q);
            if (addr_q == AWID'(DEPTH - 1))
               state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      cmd_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
      wr_ready_d  = (state_d == S_WRITE);
      busy_d      = (state_d != S_IDLE);
   end

   // State, address, burst counter and registered control outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RST_STATE;
         addr_q      <= '0;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         raddr_q     <= '0;
         din_q       <= '0;
         cmd_ready_q <= RST_CRDY;
         wr_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         raddr_q     <= raddr_d;
         din_q       <= din_d;
         cmd_ready_q <= cmd_ready_d;
         wr_ready_q  <= wr_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Read pipe valids and the 4-entry output FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         infl_q <= 2'b00;
         fcnt_q <= 3'd0;
         wp_q   <= 2'd0;
         rp_q   <= 2'd0;
         for (int i = 0; i < 4; i++)
            fifo_mem[i] <= '0;
      end else begin
         infl_q <= infl_d;
         fcnt_q <= fcnt_d;
         if (push) begin
            fifo_mem[wp_q] <= ram.dout;
            wp_q           <= wp_q + 2'd1;
         end
         if (pop)
            rp_q <= rp_q + 2'd1;
      end
   end

   assign ram.we    = we_q;
   assign ram.addr  = raddr_q;
   assign ram.din   = din_q;
   assign cmd_ready = cmd_ready_q;
   assign wr_ready  = wr_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_valid  = (fcnt_q != 3'd0);
   assign rd_data   = fifo_mem[rp_q];

endmodule
